gesture_key_conditioner: RTL and testbench

- Input stage directly upstream of the gesture power controller.
- Takes the raw, asynchronous left/right gesture push-buttons and produces clean, debounced, single-clock signals for the gesture state machine.
- Per key: a 2-flop synchroniser, a debounce FSM and a long-press detector.
- Outputs are a debounced level, a one-cycle press pulse and a one-cycle long-press pulse per key, plus a simultaneous-press flag.

---
 rtl/gesture_key_conditioner_if.sv | 20 ++
 rtl/gesture_key_conditioner.sv | 78 +++++++
 tb/tb_gesture_key_conditioner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gesture_key_conditioner_if.sv
// gesture_key_conditioner_if: raw gesture buttons in, conditioned levels and pulses out
interface gesture_key_conditioner_if;
  logic left_key_raw;
  logic right_key_raw;
  logic left_key;
  logic right_key;
  logic left_press;
  logic right_press;
  logic left_long;
  logic right_long;
  logic both_press;
  modport master(
    output left_key_raw, right_key_raw,
    input left_key, right_key, left_press, right_press, left_long, right_long, both_press
  );
  modport slave(
    input left_key_raw, right_key_raw,
    output left_key, right_key, left_press, right_press, left_long, right_long, both_press
  );
endinterface

// File: rtl/gesture_key_conditioner.sv
// gesture_key_conditioner: per-key synchroniser, debounce FSM and long-press detector
module gesture_key_conditioner #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [27:0] LONG_CYCLES = 28'd200000000,
  parameter int CNT_W = 28
) (
  input logic clk,
  input logic reset,
  gesture_key_conditioner_if.slave kif
);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES) - 1'b1;
  localparam logic [CNT_W-1:0] LG_MAX = CNT_W'(LONG_CYCLES) - 1'b1;
  logic [1:0] raw, level_v, press_v, long_v, accept_v;
  logic both;
  assign raw = {kif.right_key_raw, kif.left_key_raw};
  for (genvar k = 0; k < 2; k++) begin : g_key
    state_t st, st_nx;
    logic s1, s2, level, press, lng, long_done;
    logic accept, fire, done_nx, level_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, hold, hold_nx;
    always_ff @(posedge clk) begin
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        st <= RELEASED;
        cnt <= '0;
        hold <= '0;
        long_done <= 1'b0;
        level <= 1'b0;
        press <= 1'b0;
        lng <= 1'b0;
      end else begin
        s1 <= raw[k];
        s2 <= s1;
        st <= st_nx;
        cnt <= cnt_nx;
        hold <= hold_nx;
        long_done <= done_nx;
        level <= level_nx;
        press <= accept;
        lng <= fire;
      end
    end
    always_comb begin
      st_nx = st;
      unique case (st)
        RELEASED:     st_nx = s2 ? PRESS_PEND : RELEASED;
        PRESS_PEND:   st_nx = !s2 ? RELEASED : (cnt == DB_MAX ? PRESSED : PRESS_PEND);
        PRESSED:      st_nx = s2 ? PRESSED : RELEASE_PEND;
        RELEASE_PEND: st_nx = s2 ? PRESSED : (cnt == DB_MAX ? RELEASED : RELEASE_PEND);
      endcase
    end
    always_comb begin
      accept = st == PRESS_PEND && s2 && cnt == DB_MAX;
      fire = st == PRESSED && hold == LG_MAX && !long_done;
      cnt_nx = (st_nx == st && (st == PRESS_PEND || st == RELEASE_PEND)) ? cnt + 1'b1 : '0;
      hold_nx = accept ? '0 : (st == PRESSED && hold != LG_MAX) ? hold + 1'b1 : hold;
      done_nx = accept ? 1'b0 : long_done | fire;
      level_nx = st_nx == PRESSED || st_nx == RELEASE_PEND;
    end
    assign level_v[k] = level;
    assign press_v[k] = press;
    assign long_v[k] = lng;
    assign accept_v[k] = accept;
  end
  always_ff @(posedge clk) begin
    if (reset) both <= 1'b0;
    else both <= &accept_v;
  end
  assign kif.left_key = level_v[0];
  assign kif.right_key = level_v[1];
  assign kif.left_press = press_v[0];
  assign kif.right_press = press_v[1];
  assign kif.left_long = long_v[0];
  assign kif.right_long = long_v[1];
  assign kif.both_press = both;
endmodule

// File: tb/tb_gesture_key_conditioner.sv
// tb_gesture_key_conditioner: scoreboard bench against a run-length reference model
module tb_gesture_key_conditioner;
  localparam int D = 4;
  localparam int L = 12;
  logic clk, reset;
  gesture_key_conditioner_if kif();
  gesture_key_conditioner #(
    .DEBOUNCE_CYCLES(20'd4),
    .LONG_CYCLES(28'd12),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kif(kif)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];
  bit m1[2], m2[2], lvl[2], prev[2];
  int run[2], held[2];
  function automatic logic [6:0] model_edge(input bit rst, input bit l, input bit r);
    bit raw[2];
    bit prs[2], lng[2];
    bit s2v;
    raw[0] = l;
    raw[1] = r;
    for (int k = 0; k < 2; k++) begin
      prs[k] = 0;
      lng[k] = 0;
      if (rst) begin
        m1[k] = 0; m2[k] = 0; lvl[k] = 0; prev[k] = 0; run[k] = 0; held[k] = 0;
      end else begin
        s2v = m2[k];
        if (lvl[k] && prev[k] && held[k] < L) begin
          held[k]++;
          lng[k] = held[k] == L;
        end
        run[k] = (s2v != lvl[k]) ? run[k] + 1 : 0;
        if (run[k] == D + 1) begin
          lvl[k] = !lvl[k];
          run[k] = 0;
          prs[k] = lvl[k];
          if (lvl[k]) held[k] = 0;
        end
        prev[k] = s2v;
        m2[k] = m1[k];
        m1[k] = raw[k];
      end
    end
    return {lvl[0], lvl[1], prs[0], prs[1], lng[0], lng[1], prs[0] & prs[1]};
  endfunction
  task automatic step(input bit rst, input bit l, input bit r);
    @(negedge clk);
    reset = rst;
    kif.left_key_raw = l;
    kif.right_key_raw = r;
    exp_q.push_back(model_edge(rst, l, r));
  endtask
  task automatic hold_for(input int n, input bit l, input bit r);
    for (int i = 0; i < n; i++) step(0, l, r);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [6:0] e, g;
      e = exp_q.pop_front();
      g = {kif.left_key, kif.right_key, kif.left_press, kif.right_press,
           kif.left_long, kif.right_long, kif.both_press};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL outputs{lk,rk,lp,rp,ll,rl,bp} @%0t: got %b expected %b", $time, g, e);
      end
    end
  end
  initial begin
    int tl, tr;
    bit l, r, rst;
    reset = 1'b1;
    kif.left_key_raw = 1'b0;
    kif.right_key_raw = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    hold_for(20, 0, 0);
    hold_for(45, 1, 0);
    hold_for(10, 0, 0);
    hold_for(3, 0, 1);
    hold_for(12, 0, 0);
    hold_for(8, 1, 0);
    hold_for(2, 0, 0);
    hold_for(30, 1, 0);
    hold_for(10, 0, 0);
    hold_for(20, 1, 1);
    hold_for(10, 0, 0);
    hold_for(1, 1, 0);
    hold_for(20, 1, 1);
    hold_for(10, 0, 0);
    hold_for(3, 1, 0);
    step(1, 1, 0);
    hold_for(15, 1, 0);
    hold_for(10, 0, 0);
    tl = 0;
    tr = 0;
    l = 0;
    r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (tl == 0) begin
        l = 1'($urandom_range(0, 1));
        tl = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 6);
      end else tl--;
      if (tr == 0) begin
        r = 1'($urandom_range(0, 1));
        tr = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 6);
      end else tr--;
      rst = $urandom_range(0, 249) == 0;
      step(rst, l, r);
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
